// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter and access sequencer for the shared memory bus.
// Also owns the output-port registers at 0xE0/0xE1 and flags illegal accesses.
module mem_bus_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_req,
    input  logic       m0_we,
    input  logic [7:0] m0_addr,
    input  logic [7:0] m0_wdata,
    output logic       m0_ack,
    output logic [7:0] m0_rdata,
    input  logic       m1_req,
    input  logic       m1_we,
    input  logic [7:0] m1_addr,
    input  logic [7:0] m1_wdata,
    output logic       m1_ack,
    output logic [7:0] m1_rdata,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       ram_we,
    input  logic [7:0] mem_rdata,
    output logic [7:0] port_out_00,
    output logic [7:0] port_out_01,
    output logic       bus_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       last_grant;
    logic       cur_id;
    logic       cur_we;
    logic [2:0] wait_cnt;
    logic       grant_m1;
    logic       any_req;
    logic       cur_illegal;
    logic       port0_wr;
    logic       port1_wr;
    logic [7:0] port0_nxt;
    logic [7:0] port1_nxt;
    logic [7:0] rd_sel;
    logic       rd_capture;

    function automatic logic is_ram(input logic [7:0] a);
        return (a >= 8'h80) && (a <= 8'hDF);
    endfunction

    function automatic logic is_illegal(input logic we, input logic [7:0] a);
        logic rom_wr;
        logic in_wr;
        logic hole;
        rom_wr = we && (a < 8'h80);
        in_wr  = we && ((a == 8'hF0) || (a == 8'hF1));
        hole   = ((a >= 8'hE2) && (a <= 8'hEF)) || (a >= 8'hF2);
        return rom_wr || in_wr || hole;
    endfunction

    // On a tie the master that did not win last time is granted.
    assign any_req     = m0_req || m1_req;
    assign grant_m1    = m1_req && (!m0_req || !last_grant);
    assign cur_illegal = is_illegal(cur_we, mem_addr);

    always_comb begin
        state_nxt  = state;
        ram_we     = 1'b0;
        m0_ack     = 1'b0;
        m1_ack     = 1'b0;
        bus_err    = 1'b0;
        port0_wr   = 1'b0;
        port1_wr   = 1'b0;
        rd_capture = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) state_nxt = ISSUE;
            end
            ISSUE: begin
                ram_we   = cur_we && is_ram(mem_addr);
                port0_wr = cur_we && (mem_addr == 8'hE0);
                port1_wr = cur_we && (mem_addr == 8'hE1);
                if (MEM_LAT == 0) begin
                    state_nxt  = RESP;
                    rd_capture = 1'b1;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt <= 3'd1) begin
                    state_nxt  = RESP;
                    rd_capture = 1'b1;
                end
            end
            RESP: begin
                m0_ack    = !cur_id;
                m1_ack    = cur_id;
                bus_err   = cur_illegal;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign port0_nxt = port0_wr ? mem_wdata : port_out_00;
    assign port1_nxt = port1_wr ? mem_wdata : port_out_01;

    // Read data is sampled on entry to RESP so it is already valid in the ack cycle;
    // port reads see a write made in the same ISSUE cycle when MEM_LAT is 0.
    always_comb begin
        rd_sel = 8'h00;
        if (cur_illegal) begin
            rd_sel = 8'h00;
        end else if (mem_addr == 8'hE0) begin
            rd_sel = port0_nxt;
        end else if (mem_addr == 8'hE1) begin
            rd_sel = port1_nxt;
        end else if ((mem_addr <= 8'hDF) || (mem_addr == 8'hF0) || (mem_addr == 8'hF1)) begin
            rd_sel = mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            cur_id      <= 1'b0;
            cur_we      <= 1'b0;
            mem_addr    <= 8'h00;
            mem_wdata   <= 8'h00;
            wait_cnt    <= 3'd0;
            port_out_00 <= 8'h00;
            port_out_01 <= 8'h00;
            m0_rdata    <= 8'h00;
            m1_rdata    <= 8'h00;
        end else begin
            state <= state_nxt;
            // grant: latch the winning request
            if (state == IDLE && any_req) begin
                cur_id     <= grant_m1;
                last_grant <= grant_m1;
                cur_we     <= grant_m1 ? m1_we    : m0_we;
                mem_addr   <= grant_m1 ? m1_addr  : m0_addr;
                mem_wdata  <= grant_m1 ? m1_wdata : m0_wdata;
            end
            if (state == ISSUE) begin
                wait_cnt <= 3'(MEM_LAT);
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 3'd1;
            end
            port_out_00 <= port0_nxt;
            port_out_01 <= port1_nxt;
            if (rd_capture) begin
                if (cur_id) m1_rdata <= rd_sel;
                else        m0_rdata <= rd_sel;
            end
        end
    end

    a_one_ack: assert property (@(posedge clk) disable iff (reset) !(m0_ack && m1_ack));
    a_ack_no_we: assert property (@(posedge clk) disable iff (reset) !((m0_ack || m1_ack) && ram_we));

endmodule
